// File: rtl/mul_stream_pipe.sv
// Streaming fixed-point multiplier: product, shift, round, saturate.
// Ports: clk/rst, in_valid/in_ready/a_in/b_in/tag_in, out_valid/out_ready/p_out/tag_out/sat.
module mul_stream_pipe #(
    parameter int AW              = 16,
    parameter int BW              = 16,
    parameter int OW              = 16,
    parameter int SHIFT           = 8,
    parameter int ROUND           = 1,
    parameter int SIGNED          = 1,
    parameter int PIPELINE_STAGES = 2,
    parameter int TW              = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] a_in,
    input  logic [BW-1:0] b_in,
    input  logic [TW-1:0] tag_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] p_out,
    output logic [TW-1:0] tag_out,
    output logic          sat
);

    localparam int PW = AW + BW;
    localparam int W  = PW + 1;
    localparam int PS = PIPELINE_STAGES;

    localparam logic [W-1:0] RND =
        (ROUND != 0 && SHIFT > 0) ? (W'(1) << (SHIFT - 1)) : '0;
    localparam logic signed [W-1:0] SMAX =
        $signed((W'(1) << (OW - 1)) - W'(1));
    localparam logic signed [W-1:0] SMIN = ~SMAX;
    localparam logic [W-1:0] UMAX = (W'(1) << OW) - W'(1);

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en && !rst;

    // Operands widened to full product width so a plain multiply
    // yields the correct two's-complement low PW bits.
    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_ext;
    assign a_ext = (SIGNED != 0) ? {{BW{a_in[AW-1]}}, a_in}
                                 : {{BW{1'b0}}, a_in};
    assign b_ext = (SIGNED != 0) ? {{AW{b_in[BW-1]}}, b_in}
                                 : {{AW{1'b0}}, b_in};

    logic [PS-1:0] vld;
    logic [PW-1:0] prod_q [PS];
    logic [TW-1:0] tag_q  [PS];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            vld[0] <= in_valid;
            for (int i = 1; i < PS; i++) begin
                vld[i] <= vld[i-1];
            end
            out_valid <= vld[PS-1];
        end
    end

    // Product/tag payload needs no reset; validity is tracked by vld.
    always_ff @(posedge clk) begin
        if (en) begin
            prod_q[0] <= a_ext * b_ext;
            tag_q[0]  <= tag_in;
            for (int i = 1; i < PS; i++) begin
                prod_q[i] <= prod_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    logic [W-1:0]        ext;
    logic [W-1:0]        sum;
    logic signed [W-1:0] shr;
    logic [W-1:0]        shu;
    logic [OW-1:0]       p_nxt;
    logic                sat_nxt;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        ext     = '0;
        sum     = '0;
        shr     = '0;
        shu     = '0;
        p_nxt   = '0;
        sat_nxt = 1'b0;
        if (SIGNED != 0) begin
            ext = {prod_q[PS-1][PW-1], prod_q[PS-1]};
            sum = ext + RND;
            shr = $signed(sum) >>> SHIFT;
            if (shr > SMAX) begin
                p_nxt   = SMAX[OW-1:0];
                sat_nxt = 1'b1;
            end else if (shr < SMIN) begin
                p_nxt   = SMIN[OW-1:0];
                sat_nxt = 1'b1;
            end else begin
                p_nxt = shr[OW-1:0];
            end
        end else begin
            ext = {1'b0, prod_q[PS-1]};
            sum = ext + RND;
            shu = sum >> SHIFT;
            if (shu > UMAX) begin
                p_nxt   = UMAX[OW-1:0];
                sat_nxt = 1'b1;
            end else begin
                p_nxt = shu[OW-1:0];
            end
        end
    end

    // Result registers load only on a valid result so they stay
    // quiet while bubbles pass through.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_out   <= '0;
            tag_out <= '0;
            sat     <= 1'b0;
        end else if (en && vld[PS-1]) begin
            p_out   <= p_nxt;
            tag_out <= tag_q[PS-1];
            sat     <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_mul_stream_pipe.sv
// Directed bench for mul_stream_pipe (Q8.8 signed, round and truncate builds).
// Scoreboard tracks every accepted pair; explicit checks cover latency/stall/reset.
module tb_mul_stream_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p_out;
    logic [3:0]  tag_out;
    logic        sat;

    logic        t_in_ready;
    logic        t_out_valid;
    logic [15:0] t_p_out;
    logic [3:0]  t_tag_out;
    logic        t_sat;

    always #5 clk = ~clk;

    mul_stream_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .p_out(p_out), .tag_out(tag_out), .sat(sat)
    );

    mul_stream_pipe #(.ROUND(0)) dut_t (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(t_in_ready),
        .a_in(a_in), .b_in(b_in), .tag_in(tag_in),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .p_out(t_p_out), .tag_out(t_tag_out), .sat(t_sat)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input logic [15:0] a,
                                          input logic [15:0] b);
        longint p;
        logic [15:0] r;
        logic s;
        p = longint'($signed(a)) * longint'($signed(b));
        p = (p + 128) >>> 8;
        if (p > 32767) begin
            r = 16'h7FFF; s = 1'b1;
        end else if (p < -32768) begin
            r = 16'h8000; s = 1'b1;
        end else begin
            r = p[15:0]; s = 1'b0;
        end
        return {s, r};
    endfunction

    logic [15:0] exp_p;
    logic        exp_s;
    logic [20:0] sb [$];
    logic [20:0] e;
    logic        hold_v = 1'b0;
    logic [15:0] hold_p;
    logic [3:0]  hold_t;
    logic        hold_s;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_p", p_out, hold_p);
                chk("hold_tag", tag_out, hold_t);
                chk("hold_sat", sat, hold_s);
            end
            if (in_valid && in_ready)
                sb.push_back({exp_p, exp_s, tag_in});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_p", p_out, e[20:5]);
                    chk("sb_sat", sat, e[4]);
                    chk("sb_tag", tag_out, e[3:0]);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_p = p_out;
            hold_t = tag_out;
            hold_s = sat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] t, input logic [15:0] ep,
                         input logic es);
        a_in     = a;
        b_in     = b;
        tag_in   = t;
        exp_p    = ep;
        exp_s    = es;
        in_valid = 1'b1;
    endtask

    task automatic one(input string nm, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] t,
                       input logic [15:0] ep, input logic es,
                       input logic [15:0] tp);
        drive(a, b, t, ep, es);
        chk({nm, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        tick();
        chk({nm, "_early"}, out_valid, 0);
        tick();
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_p"}, p_out, ep);
        chk({nm, "_sat"}, sat, es);
        chk({nm, "_tag"}, tag_out, t);
        chk({nm, "_trunc"}, t_p_out, tp);
        tick();
    endtask

    int          k;
    int          cyc;
    logic        acc;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [7:0]  rb8;
    logic [16:0] m;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        tag_in    = '0;
        exp_p     = '0;
        exp_s     = 1'b0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_p", p_out, 0);
        chk("rst_tag", tag_out, 0);
        chk("rst_sat", sat, 0);
        chk("rst_rdy", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", in_ready, 1);

        one("basic",   16'h0180, 16'h0200, 4'd3, 16'h0300, 1'b0, 16'h0300);
        one("rnd_pos", 16'h0001, 16'h0080, 4'd1, 16'h0001, 1'b0, 16'h0000);
        one("rnd_neg", 16'hFFFF, 16'h0080, 4'd2, 16'h0000, 1'b0, 16'hFFFF);
        one("sat_pp",  16'h7FFF, 16'h7FFF, 4'd4, 16'h7FFF, 1'b1, 16'h7FFF);
        one("sat_np",  16'h8000, 16'h7FFF, 4'd5, 16'h8000, 1'b1, 16'h8000);
        one("sat_nn",  16'h8000, 16'h8000, 4'd6, 16'h7FFF, 1'b1, 16'h7FFF);
        one("neg",     16'hFE80, 16'h0200, 4'd7, 16'hFD00, 1'b0, 16'hFD00);
        one("max_in",  16'h7FFF, 16'h0100, 4'd8, 16'h7FFF, 1'b0, 16'h7FFF);
        one("min_in",  16'h8000, 16'h0100, 4'd9, 16'h8000, 1'b0, 16'h8000);

        // Streaming with random backpressure
        k   = 0;
        cyc = 0;
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        while (k < 200 && cyc < 4000) begin
            m = model(ra, rb);
            drive(ra, rb, 4'(k), m[15:0], m[16]);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            tick();
            cyc++;
            if (acc) begin
                k++;
                ra = 16'($urandom);
                if (k % 2 == 1) begin
                    rb8 = 8'($urandom);
                    rb  = {{8{rb8[7]}}, rb8};
                end else begin
                    rb = 16'($urandom);
                end
            end
        end
        chk("stream_cnt", k, 200);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("stream_drain", sb.size(), 0);

        // Stall with full pipeline
        out_ready = 1'b0;
        drive(16'h0100, 16'h0100, 4'd5, 16'h0100, 1'b0);
        tick();
        drive(16'h0200, 16'h0300, 4'd6, 16'h0600, 1'b0);
        tick();
        drive(16'hFF00, 16'h0100, 4'd7, 16'hFF00, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_rdy", in_ready, 0);
            chk("stall_valid", out_valid, 1);
            chk("stall_p", p_out, 16'h0100);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_tag", tag_out, 5 + i);
            tick();
        end
        chk("drain_end", out_valid, 0);

        // Reset with three pairs in flight
        out_ready = 1'b0;
        drive(16'h0400, 16'h0100, 4'd11, 16'h0400, 1'b0);
        tick();
        drive(16'h0500, 16'h0100, 4'd12, 16'h0500, 1'b0);
        tick();
        drive(16'h0600, 16'h0100, 4'd13, 16'h0600, 1'b0);
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("mid_rst_rdy", in_ready, 0);
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        #1;
        chk("mid_rst_rdy1", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("stale", out_valid, 0);
            tick();
        end
        one("post_rst", 16'h0300, 16'h0100, 4'd10, 16'h0300, 1'b0, 16'h0300);
        chk("post_rst_sb", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
